avalon_enforcer: RTL and testbench

AVALON_ENFORCER -- requirements
Module: avalon_enforcer

---
 rtl/avalon_enforcer_if.sv | 16 +
 rtl/avalon_enforcer.sv | 70 +++++++
 tb/tb_avalon_enforcer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/avalon_enforcer_if.sv
// Avalon-ST stream bundle shared by the untrusted source and the enforced sink.
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 16
);
  localparam int EW = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
  logic                             valid;
  logic                             sop;
  logic                             eop;
  logic [EW-1:0]                    empty;
  logic                             rdy;

  modport master (output data, valid, sop, eop, empty, input rdy);
  modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/avalon_enforcer.sv
// Repairs sop/eop framing on an untrusted Avalon-ST stream; zero-latency datapath,
// one bit of packet state, and pulse flags for the two framing violations.
module avalon_enforcer #(
  parameter int DATA_WIDTH_IN_BYTES = 16
) (
  input  logic        clk,
  input  logic        rst,
  avalon_st_if.slave  untrusted,
  avalon_st_if.master enforced,
  output logic        valid_out_of_packet,
  output logic        second_sop_indc
);
  localparam int EW = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

  typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_e;

  state_e        state_q, state_d;
  logic          xfer;
  logic          out_valid, out_sop, out_eop;
  logic [EW-1:0] out_empty;
  logic          voop, ssop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    out_empty = '0;
    voop      = 1'b0;
    ssop      = 1'b0;
    xfer      = untrusted.valid && enforced.rdy;
    if (!rst && untrusted.valid) begin
      unique case (state_q)
        IDLE: begin
          if (untrusted.sop) begin
            out_valid = 1'b1;
            out_sop   = 1'b1;
            out_eop   = untrusted.eop;
            if (xfer && !untrusted.eop) state_d = IN_PKT;
          end else begin
            voop = enforced.rdy;
          end
        end
        IN_PKT: begin
          // A stray sop inside a packet is demoted to a continuation beat.
          out_valid = 1'b1;
          out_eop   = untrusted.eop;
          ssop      = untrusted.sop && enforced.rdy;
          if (xfer && untrusted.eop) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    if (out_eop) out_empty = untrusted.empty;
  end

  assign untrusted.rdy       = enforced.rdy;
  assign enforced.data       = untrusted.data;
  assign enforced.valid      = out_valid;
  assign enforced.sop        = out_sop;
  assign enforced.eop        = out_eop;
  assign enforced.empty      = out_empty;
  assign valid_out_of_packet = voop;
  assign second_sop_indc     = ssop;
endmodule

// File: tb/tb_avalon_enforcer.sv
// Directed framing scenarios plus randomized traffic against a packet-tracking model.
module tb_avalon_enforcer;
  localparam int N  = 16;
  localparam int DW = 8 * N;
  localparam int EW = $clog2(N);

  logic clk = 1'b0;
  logic rst;
  logic voop, ssop;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   model_on = 1'b0;
  bit   in_pkt;

  always #5 clk = ~clk;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(N)) u_if ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(N)) e_if ();

  avalon_enforcer #(.DATA_WIDTH_IN_BYTES(N)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .untrusted           (u_if),
    .enforced            (e_if),
    .valid_out_of_packet (voop),
    .second_sop_indc     (ssop)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an accepted beat either opens a packet (sop in idle, no eop) or
  // closes one (eop while open); everything else leaves the packet status alone.
  always @(posedge clk or posedge rst) begin
    if (rst) in_pkt <= 1'b0;
    else if (u_if.valid && e_if.rdy) begin
      if (in_pkt) in_pkt <= !u_if.eop;
      else if (u_if.sop) in_pkt <= !u_if.eop;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      logic live, fwd, x_eop;
      live  = u_if.valid && !rst;
      fwd   = live && (in_pkt || u_if.sop);
      x_eop = fwd && u_if.eop;
      check("data",  e_if.data, u_if.data);
      check("urdy",  DW'(u_if.rdy), DW'(e_if.rdy));
      check("valid", DW'(e_if.valid), DW'(fwd));
      check("sop",   DW'(e_if.sop), DW'(fwd && !in_pkt && u_if.sop));
      check("eop",   DW'(e_if.eop), DW'(x_eop));
      check("empty", DW'(e_if.empty), x_eop ? DW'(u_if.empty) : '0);
      check("voop",  DW'(voop), DW'(live && e_if.rdy && !in_pkt && !u_if.sop));
      check("ssop",  DW'(ssop), DW'(live && e_if.rdy && in_pkt && u_if.sop));
    end
  end

  // Drive one cycle of inputs after the edge, then return just past the falling edge.
  task automatic beat(input bit v, input bit s, input bit e, input int emp, input bit r,
                      input logic [DW-1:0] d);
    @(posedge clk); #1;
    u_if.valid = v; u_if.sop = s; u_if.eop = e; u_if.empty = EW'(emp);
    e_if.rdy = r; u_if.data = d;
    @(negedge clk); #1;
  endtask

  initial begin
    logic [DW-1:0] d22, rd;
    int nbeats;
    d22 = {N{8'h22}};
    rst = 1'b1;
    u_if.valid = 0; u_if.sop = 0; u_if.eop = 0; u_if.empty = '0; u_if.data = '0;
    e_if.rdy = 1'b1;
    @(negedge clk); #1;
    check("rst_valid", DW'(e_if.valid), '0);
    check("rst_voop",  DW'(voop), '0);
    // valid beat without sop under reset: no flag, nothing forwarded
    u_if.valid = 1; #1;
    check("rst_valid_in", DW'(e_if.valid), '0);
    check("rst_voop_in",  DW'(voop), '0);
    u_if.valid = 0;
    @(posedge clk); #1; rst = 1'b0;
    model_on = 1'b1;

    // three-beat packet
    beat(1, 1, 0, 0, 1, d22);
    check("p3_sop", {e_if.valid, e_if.sop, e_if.eop, voop, ssop}, 5'b11000);
    beat(1, 0, 0, 0, 1, d22);
    check("p3_mid", {e_if.valid, e_if.sop, e_if.eop, voop, ssop}, 5'b10000);
    beat(1, 0, 1, 1, 1, d22);
    check("p3_eop", {e_if.valid, e_if.sop, e_if.eop, voop, ssop}, 5'b10100);
    check("p3_empty", DW'(e_if.empty), DW'(1));
    check("p3_data", e_if.data, d22);

    // single-beat packet
    beat(1, 1, 1, 1, 1, d22);
    check("p1_flags", {e_if.valid, e_if.sop, e_if.eop, voop, ssop}, 5'b11100);
    check("p1_empty", DW'(e_if.empty), DW'(1));

    // idle, then out-of-packet beat for exactly one cycle
    beat(0, 0, 0, 0, 1, '0);
    check("oop_idle", DW'(voop), '0);
    beat(1, 0, 0, 3, 1, d22);
    check("oop_flags", {e_if.valid, e_if.sop, e_if.eop, e_if.empty, voop}, {4'b0000, 5'b00001} >> 0);
    beat(0, 0, 0, 0, 1, '0);
    check("oop_after", DW'(voop), '0);

    // sop, data, sop, data, eop
    nbeats = 0;
    for (int i = 0; i < 5; i++) begin
      beat(1, (i == 0 || i == 2), (i == 4), 2, 1, DW'(i));
      nbeats += int'(e_if.valid);
      if (i == 2) check("ss_third", {e_if.sop, ssop}, 2'b01);
      else        check("ss_other", DW'(ssop), '0);
    end
    check("ss_beats", DW'(nbeats), DW'(5));
    beat(1, 0, 0, 0, 1, d22);
    check("ss_closed", DW'(voop), DW'(1));

    // back-pressure: classification visible, state frozen, no flags
    beat(1, 0, 0, 0, 0, d22);
    check("bp_oop", {u_if.rdy, e_if.valid, voop}, 3'b000);
    beat(1, 1, 0, 0, 0, d22);
    check("bp_sop", {u_if.rdy, e_if.valid, e_if.sop, voop, ssop}, 5'b01100);
    beat(1, 0, 0, 0, 1, d22);
    check("bp_held", {e_if.valid, voop}, 2'b01);

    // reset mid-packet abandons it
    beat(1, 1, 0, 0, 1, d22);
    beat(0, 0, 0, 0, 1, '0);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", DW'(e_if.valid), '0);
    @(posedge clk); #1; rst = 1'b0;
    beat(1, 0, 0, 0, 1, d22);
    check("rst_mid_drop", {e_if.valid, voop}, 2'b01);

    // randomized traffic; model compares every cycle
    for (int i = 0; i < 3000; i++) begin
      rd = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      u_if.valid = ($urandom_range(0, 9) < 7);
      u_if.sop   = ($urandom_range(0, 9) < 3);
      u_if.eop   = ($urandom_range(0, 9) < 3);
      u_if.empty = EW'($urandom);
      u_if.data  = rd;
      e_if.rdy   = ($urandom_range(0, 9) < 8);
      rst        = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; u_if.valid = 0;
    @(negedge clk); #1;
    model_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
